// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes, decoder states, colour constants and default window limits for the LCD SPI command decoder.
package lcd_pkg;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  localparam logic [7:0] COLMOD_RST = 8'h55;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 320;

  typedef enum logic [2:0] {
    ST_IDLE, ST_COLMOD_P, ST_CASET_P, ST_RASET_P, ST_PIXEL, ST_IGNORE
  } dec_state_e;

  // raise a backwards end up to start first, then clamp to the panel edge
  function automatic logic [8:0] fix_end(input logic [8:0] s, input logic [8:0] e, input logic [8:0] lim);
    logic [8:0] t;
    t = (e < s) ? s : e;
    return (t > lim) ? lim : t;
  endfunction
endpackage

// File: rtl/lcd_spi_byte_rx.sv
// lcd_spi_byte_rx: synchronises the SPI pins, detects sclk rising edges and assembles MSB-first bytes.
module lcd_spi_byte_rx
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  input  logic       dc,
  output logic       stb,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       cs_s
);
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0] s;
  logic       sclk_d1_q, rise;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s[3] & ~sclk_d1_q;
  assign cs_s    = s[1];
  assign rx_dc   = s[0];
  assign rx_byte = {shift_q[6:0], s[2]};
  // the 8th edge still delivers even if cs rises in the same cycle
  assign stb     = rise & (cnt_q == 3'd7);
  always_comb begin
    sync_d[0] = {sclk, mosi, cs, dc};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    cnt_d   = cs_s ? 3'd0 : rise ? cnt_q + 3'd1 : cnt_q;
    shift_d = (rise && !cs_s) ? rx_byte : shift_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{4'b0010}};
      sclk_d1_q <= 1'b0;
      cnt_q     <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      sync_q    <= sync_d;
      sclk_d1_q <= s[3];
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
    end
  end
endmodule

// File: rtl/lcd_spi_cmd_decoder.sv
// lcd_spi_cmd_decoder: ST7789-style command decoder producing addressed pixel writes from the LCD SPI link.
// Optional LCD_DEC_FRAME_SUM_EN adds a per-frame wrapping colour sum on frame_sum.
module lcd_spi_cmd_decoder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LCD_WIDTH   = DEF_WIDTH,
  parameter int LCD_HEIGHT  = DEF_HEIGHT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_sclk,
  input  logic        lcd_mosi,
  input  logic        lcd_cs,
  input  logic        lcd_dc,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        frame_done,
  output logic        disp_on,
  output logic        sleep_out,
`ifdef LCD_DEC_FRAME_SUM_EN
  output logic [15:0] frame_sum,
`endif
  output logic [7:0]  colmod
);
  localparam logic [7:0] XMAX = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] YMAX = 9'(LCD_HEIGHT - 1);
  logic       rx_stb, rx_dc, cs_s;
  logic [7:0] rx_byte;
  dec_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [8:0]  tmp_q, tmp_d;
  logic        half_q, half_d;
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, x_q, x_d;
  logic [8:0]  ys_q, ys_d, ye_q, ye_d, y_q, y_d;
  logic        bv_q, bv_d, bd_q, bd_d, cv_q, cv_d, pv_q, pv_d, fd_q, fd_d;
  logic        don_q, don_d, slp_q, slp_d;
  logic [7:0]  bdat_q, bdat_d, cc_q, cc_d, px_q, px_d, cm_q, cm_d;
  logic [8:0]  py_q, py_d;
  logic [15:0] pc_q, pc_d;
`ifdef LCD_DEC_FRAME_SUM_EN
  logic [15:0] acc_q, acc_d, fs_q, fs_d, pix_sum;
  assign pix_sum   = acc_q + {hi_q, rx_byte};
  assign frame_sum = fs_q;
`endif
  lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk(clk), .rst_n(rst_n), .sclk(lcd_sclk), .mosi(lcd_mosi), .cs(lcd_cs), .dc(lcd_dc),
    .stb(rx_stb), .rx_byte(rx_byte), .rx_dc(rx_dc), .cs_s(cs_s)
  );
  assign byte_valid = bv_q;   assign byte_data = bdat_q; assign byte_is_data = bd_q;
  assign cmd_valid  = cv_q;   assign cmd_code  = cc_q;   assign pix_valid    = pv_q;
  assign pix_x      = px_q;   assign pix_y     = py_q;   assign pix_color    = pc_q;
  assign frame_done = fd_q;   assign disp_on   = don_q;  assign sleep_out    = slp_q;
  assign colmod     = cm_q;
  always_comb begin
    state_d = state_q; idx_d = idx_q; hi_d = hi_q; tmp_d = tmp_q; half_d = half_q;
    xs_d = xs_q; xe_d = xe_q; x_d = x_q; ys_d = ys_q; ye_d = ye_q; y_d = y_q;
    bv_d = rx_stb; bd_d = bd_q; bdat_d = bdat_q; cv_d = 1'b0; cc_d = cc_q;
    pv_d = 1'b0; fd_d = 1'b0; px_d = px_q; py_d = py_q; pc_d = pc_q;
    don_d = don_q; slp_d = slp_q; cm_d = cm_q;
`ifdef LCD_DEC_FRAME_SUM_EN
    acc_d = acc_q; fs_d = fs_q;
`endif
    if (rx_stb) begin
      bdat_d = rx_byte;
      bd_d   = rx_dc;
      if (!rx_dc) begin
        cv_d = 1'b1; cc_d = rx_byte; state_d = ST_IDLE; idx_d = 2'd0; half_d = 1'b0;
        case (rx_byte)
          OP_SWRESET: begin
            don_d = 1'b0; slp_d = 1'b0; cm_d = COLMOD_RST;
            xs_d = 8'd0; xe_d = XMAX; ys_d = 9'd0; ye_d = YMAX; x_d = 8'd0; y_d = 9'd0;
            px_d = 8'd0; py_d = 9'd0; pc_d = RGB565_BLACK;
`ifdef LCD_DEC_FRAME_SUM_EN
            acc_d = 16'd0; fs_d = 16'd0;
`endif
          end
          OP_SLPIN:   slp_d = 1'b0;
          OP_SLPOUT:  slp_d = 1'b1;
          OP_DISPOFF: don_d = 1'b0;
          OP_DISPON:  don_d = 1'b1;
          OP_COLMOD:  state_d = ST_COLMOD_P;
          OP_CASET:   state_d = ST_CASET_P;
          OP_RASET:   state_d = ST_RASET_P;
          OP_RAMWR: begin
            state_d = ST_PIXEL; x_d = xs_q; y_d = ys_q;
`ifdef LCD_DEC_FRAME_SUM_EN
            acc_d = 16'd0;
`endif
          end
          default:    state_d = ST_IGNORE;
        endcase
      end else begin
        case (state_q)
          ST_COLMOD_P: begin
            cm_d = rx_byte; state_d = ST_IDLE;
          end
          ST_CASET_P, ST_RASET_P: begin
            idx_d = idx_q + 2'd1;
            hi_d  = idx_q[0] ? hi_q : rx_byte;
            tmp_d = (idx_q == 2'd1) ? {hi_q[0], rx_byte} : tmp_q;
            if (idx_q == 2'd3) begin
              state_d = ST_IDLE;
              xs_d = (state_q == ST_CASET_P) ? tmp_q[7:0] : xs_q;
              xe_d = (state_q == ST_CASET_P) ? 8'(fix_end({1'b0, tmp_q[7:0]}, {1'b0, rx_byte}, {1'b0, XMAX})) : xe_q;
              ys_d = (state_q == ST_RASET_P) ? tmp_q : ys_q;
              ye_d = (state_q == ST_RASET_P) ? fix_end(tmp_q, {hi_q[0], rx_byte}, YMAX) : ye_q;
            end
          end
          ST_PIXEL: begin
            half_d = ~half_q;
            hi_d   = half_q ? hi_q : rx_byte;
            if (half_q) begin
              pv_d = 1'b1; pc_d = {hi_q, rx_byte}; px_d = x_q; py_d = y_q;
`ifdef LCD_DEC_FRAME_SUM_EN
              acc_d = pix_sum;
`endif
              x_d = (x_q == xe_q) ? xs_q : x_q + 8'd1;
              if (x_q == xe_q) begin
                y_d  = (y_q == ye_q) ? ys_q : y_q + 9'd1;
                fd_d = (y_q == ye_q);
`ifdef LCD_DEC_FRAME_SUM_EN
                acc_d = (y_q == ye_q) ? 16'd0 : pix_sum;
                fs_d  = (y_q == ye_q) ? pix_sum : fs_q;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
    if (cs_s) half_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; idx_q <= 2'd0; hi_q <= 8'd0; tmp_q <= 9'd0; half_q <= 1'b0;
      xs_q <= 8'd0; xe_q <= XMAX; x_q <= 8'd0; ys_q <= 9'd0; ye_q <= YMAX; y_q <= 9'd0;
      bv_q <= 1'b0; bd_q <= 1'b0; bdat_q <= 8'd0; cv_q <= 1'b0; cc_q <= 8'd0;
      pv_q <= 1'b0; fd_q <= 1'b0; px_q <= 8'd0; py_q <= 9'd0; pc_q <= 16'd0;
      don_q <= 1'b0; slp_q <= 1'b0; cm_q <= COLMOD_RST;
`ifdef LCD_DEC_FRAME_SUM_EN
      acc_q <= 16'd0; fs_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d; idx_q <= idx_d; hi_q <= hi_d; tmp_q <= tmp_d; half_q <= half_d;
      xs_q <= xs_d; xe_q <= xe_d; x_q <= x_d; ys_q <= ys_d; ye_q <= ye_d; y_q <= y_d;
      bv_q <= bv_d; bd_q <= bd_d; bdat_q <= bdat_d; cv_q <= cv_d; cc_q <= cc_d;
      pv_q <= pv_d; fd_q <= fd_d; px_q <= px_d; py_q <= py_d; pc_q <= pc_d;
      don_q <= don_d; slp_q <= slp_d; cm_q <= cm_d;
`ifdef LCD_DEC_FRAME_SUM_EN
      acc_q <= acc_d; fs_q <= fs_d;
`endif
    end
  end
endmodule

// File: tb/tb_lcd_spi_cmd_decoder.sv
// tb_lcd_spi_cmd_decoder: directed SPI transactions against lcd_spi_cmd_decoder with hand-computed expectations.
// Exercises the LCD_DEC_FRAME_SUM_EN checks only when that macro is defined.
module tb_lcd_spi_cmd_decoder;
  localparam int HP = 13;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lcd_sclk = 1'b0, lcd_mosi = 1'b0, lcd_cs = 1'b1, lcd_dc = 1'b0;
  logic byte_valid, byte_is_data, cmd_valid, pix_valid, frame_done, disp_on, sleep_out;
  logic [7:0] byte_data, cmd_code, pix_x, colmod;
  logic [8:0] pix_y;
  logic [15:0] pix_color;
`ifdef LCD_DEC_FRAME_SUM_EN
  logic [15:0] frame_sum;
`endif
  int n_cmp = 0, n_bad = 0, n_bv = 0;
  logic [7:0]  cq[$];
  logic [33:0] pq[$];

  lcd_spi_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi), .lcd_cs(lcd_cs),
    .lcd_dc(lcd_dc), .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_color(pix_color), .frame_done(frame_done), .disp_on(disp_on),
    .sleep_out(sleep_out),
`ifdef LCD_DEC_FRAME_SUM_EN
    .frame_sum(frame_sum),
`endif
    .colmod(colmod)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) n_bv <= n_bv + 1;
    if (cmd_valid) cq.push_back(cmd_code);
    if (pix_valid) pq.push_back({frame_done, pix_y, pix_x, pix_color});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bits(input logic dc, input logic [7:0] b, input int n);
    lcd_dc = dc;
    for (int i = 0; i < n; i++) begin
      lcd_mosi = b[7-i];
      repeat (HP) @(posedge clk);
      lcd_sclk = 1'b1;
      repeat (HP) @(posedge clk);
      lcd_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    lcd_cs = 1'b0;
    repeat (HP) @(posedge clk);
  endtask

  task automatic cs_hi();
    repeat (HP) @(posedge clk);
    lcd_cs = 1'b1;
    repeat (2 * HP) @(posedge clk);
  endtask

  task automatic cmd(input logic [7:0] c);
    bits(1'b0, c, 8);
  endtask

  task automatic dat(input logic [7:0] d);
    bits(1'b1, d, 8);
  endtask

  task automatic win(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d);
    cs_lo(); cmd(op); dat(a); dat(b); dat(c); dat(d); cs_hi();
  endtask

  task automatic pix_chk(input string tag, input logic [7:0] x, input logic [8:0] y,
                         input logic [15:0] c, input logic fd);
    logic [33:0] e;
    chk({tag, "_avail"}, 64'(pq.size() > 0), 64'd1);
    if (pq.size() > 0) begin
      e = pq.pop_front();
      chk({tag, "_pix"}, 64'(e), 64'({fd, y, x, c}));
    end
  endtask

  initial begin
    int bv0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_bv", 64'(byte_valid), 64'd0);
    chk("rst_cmd", 64'(cmd_code), 64'd0);
    chk("rst_colmod", 64'(colmod), 64'h55);
    chk("rst_disp", 64'({disp_on, sleep_out, pix_valid, frame_done}), 64'd0);
    chk("rst_pix", 64'({pix_x, pix_y, pix_color}), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    cs_lo(); cmd(8'h29); cmd(8'h11); cs_hi();
    chk("cmd_cnt", 64'(cq.size()), 64'd2);
    if (cq.size() == 2) begin
      chk("cmd0", 64'(cq[0]), 64'h29);
      chk("cmd1", 64'(cq[1]), 64'h11);
    end
    chk("disp_on", 64'(disp_on), 64'd1);
    chk("sleep_out", 64'(sleep_out), 64'd1);
    cq.delete();

    cs_lo(); cmd(8'h3A); dat(8'h66); cs_hi();
    chk("colmod_set", 64'(colmod), 64'h66);
    chk("data_flag", 64'(byte_is_data), 64'd1);
    cs_lo(); cmd(8'h01); cs_hi();
    chk("swrst_colmod", 64'(colmod), 64'h55);
    chk("swrst_disp", 64'({disp_on, sleep_out}), 64'd0);
    chk("swrst_cmd", 64'(cmd_code), 64'h01);

    win(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B);
    win(8'h2B, 8'h00, 8'h05, 8'h00, 8'h05);
    cs_lo(); cmd(8'h2C); dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0); cs_hi();
    pix_chk("p1", 8'd10, 9'd5, 16'hF800, 1'b0);
    pix_chk("p2", 8'd11, 9'd5, 16'h07E0, 1'b1);

    win(8'h2A, 8'h00, 8'h14, 8'h00, 8'h0A);
    win(8'h2B, 8'h00, 8'h05, 8'h00, 8'h0A);
    cs_lo(); cmd(8'h2C); dat(8'h00); dat(8'h1F); dat(8'hFF); dat(8'hFF); cs_hi();
    pix_chk("back1", 8'd20, 9'd5, 16'h001F, 1'b0);
    pix_chk("back2", 8'd20, 9'd6, 16'hFFFF, 1'b0);

    win(8'h2A, 8'h00, 8'hEF, 8'h00, 8'hFF);
    win(8'h2B, 8'h01, 8'h3F, 8'h01, 8'hFF);
    cs_lo(); cmd(8'h2C); dat(8'h12); dat(8'h34); cs_hi();
    pix_chk("clamp", 8'd239, 9'd319, 16'h1234, 1'b1);

    cs_lo(); cmd(8'h2C); dat(8'hAB); cs_hi();
    cs_lo(); dat(8'h56); dat(8'h78); cs_hi();
    pix_chk("half_clr", 8'd239, 9'd319, 16'h5678, 1'b1);

    cs_lo(); cmd(8'hB0); dat(8'h12); dat(8'h34); cs_hi();
    chk("ignore_pix", 64'(pq.size()), 64'd0);
    chk("ignore_cmd", 64'(cmd_code), 64'hB0);

    cq.delete();
    bv0 = n_bv;
    cs_lo(); bits(1'b0, 8'hA5, 4); cs_hi();
    cs_lo(); cmd(8'h2C); cs_hi();
    chk("partial_bv", 64'(n_bv - bv0), 64'd1);
    chk("partial_cmd", 64'(cmd_code), 64'h2C);
    chk("partial_byte", 64'(byte_data), 64'h2C);
    chk("partial_cq", 64'(cq.size()), 64'd1);

`ifdef LCD_DEC_FRAME_SUM_EN
    win(8'h2A, 8'h00, 8'h00, 8'h00, 8'h00);
    win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
    cs_lo(); cmd(8'h2C); dat(8'h00); dat(8'h01); cs_hi();
    chk("fsum_hold", 64'(frame_sum), 64'h0000);
    cs_lo(); dat(8'hFF); dat(8'hFF); cs_hi();
    pix_chk("fs1", 8'd0, 9'd0, 16'h0001, 1'b0);
    pix_chk("fs2", 8'd0, 9'd1, 16'hFFFF, 1'b1);
    chk("fsum_wrap", 64'(frame_sum), 64'h0000);
    cs_lo(); dat(8'h12); dat(8'h34); dat(8'h11); dat(8'h11); cs_hi();
    chk("fsum_2", 64'(frame_sum), 64'h2345);
    pq.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
